apb_completer_regs: RTL and testbench

//  APB completer (slave) for the 8-bit APB bus driven by our APB requester FSM.

---
 rtl/apb_completer_regs_if.sv | 27 ++
 rtl/apb_completer_regs.sv | 110 +++++++++++
 tb/tb_apb_completer_regs.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_completer_regs_if.sv
// APB bus bundle between the requester FSM and the register completer.
// The master modport drives the request side, the slave modport answers it.
interface apb_completer_regs_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_completer_regs.sv
// APB completer with a small register file, programmable wait states and
// a read-only ID register in the top slot; register 0 is exported as ctrl_out.
module apb_completer_regs #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] ID_VAL      = DATA_W'(8'hA5)
) (
  input  logic                  clk,
  input  logic                  reset,
  apb_completer_regs_if.slave   bus,
  output logic [DATA_W-1:0]     ctrl_out
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] ID_ADDR    = ADDR_W'(NUM_REGS - 1);
  localparam logic [3:0]        WAIT_W     = 4'(WAIT_CYCLES);

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [NUM_REGS-1];

  logic              inRange;
  logic              isId;
  logic              errResp;
  logic              accessOn;
  logic              readyNow;
  logic [DATA_W-1:0] readVal;

  // Decode is taken from the live bus in the completing cycle; the requester
  // keeps paddr/pwrite stable for the whole transfer.
  always_comb begin
    inRange  = {1'b0, bus.paddr} < NUM_REGS_W;
    isId     = bus.paddr == ID_ADDR;
    errResp  = !inRange || (bus.pwrite && isId);
    accessOn = (state_q == ACCESS) && bus.psel && bus.penable;
    readyNow = accessOn && (cnt_q == WAIT_W);
    readVal  = '0;
    if (isId) begin
      readVal = ID_VAL;
    end
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (bus.paddr == ADDR_W'(i)) begin
        readVal = regs_q[i];
      end
    end
  end

  assign bus.pready  = readyNow;
  assign bus.pslverr = readyNow && errResp;
  assign bus.prdata  = (readyNow && !bus.pwrite && !errResp) ? readVal : '0;
  assign ctrl_out    = regs_q[0];

  always_comb begin
    regs_d = regs_q;
    if (readyNow && bus.pwrite && !errResp) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (bus.paddr == ADDR_W'(i)) begin
          regs_d[i] = bus.pwdata;
        end
      end
    end
  end

  // A dropped psel/penable during ACCESS abandons the transfer silently.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          state_d = ACCESS;
          cnt_d   = 4'd0;
        end
      end
      ACCESS: begin
        if (!accessOn || readyNow) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: two instances (zero and one wait state)
// driven by directed and random APB transfers against a register-file model.
module tb_apb_completer_regs;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] ctrl0, ctrl1;

  always #5 clk = ~clk;

  apb_completer_regs_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
  apb_completer_regs_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

  apb_completer_regs #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(8), .WAIT_CYCLES(0), .ID_VAL(8'hA5)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .ctrl_out(ctrl0)
  );

  apb_completer_regs #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(8), .WAIT_CYCLES(1), .ID_VAL(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .ctrl_out(ctrl1)
  );

  int checks = 0;
  int errors = 0;
  int waitOf [2] = '{0, 1};
  logic [7:0] mdl [2][8];

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input int w, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, w, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) mdl[w][i] = 8'h00;
      mdl[w][7] = 8'hA5;
    end
  endtask

  task automatic drive(input int w, input logic s, input logic e, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
    if (w == 0) begin
      bus0.psel = s; bus0.penable = e; bus0.pwrite = wr; bus0.paddr = a; bus0.pwdata = d;
    end else begin
      bus1.psel = s; bus1.penable = e; bus1.pwrite = wr; bus1.paddr = a; bus1.pwdata = d;
    end
  endtask

  function automatic logic [7:0] rdyOf(input int w);
    return (w == 0) ? {7'd0, bus0.pready} : {7'd0, bus1.pready};
  endfunction

  function automatic logic [7:0] errOf(input int w);
    return (w == 0) ? {7'd0, bus0.pslverr} : {7'd0, bus1.pslverr};
  endfunction

  function automatic logic [7:0] rdOf(input int w);
    return (w == 0) ? bus0.prdata : bus1.prdata;
  endfunction

  function automatic logic [7:0] ctrlOf(input int w);
    return (w == 0) ? ctrl0 : ctrl1;
  endfunction

  // One full APB transfer: setup, access until pready (bounded), completion edge.
  task automatic applyStimulus(input int w, input logic wr, input logic [7:0] addr,
                               input logic [7:0] data, input bit b2b);
    logic       expErr;
    logic [7:0] expRd;
    bit         done;
    expErr = (addr >= 8) || (wr && addr == 8'd7);
    expRd  = (wr || expErr) ? 8'h00 : mdl[w][addr[2:0]];
    drive(w, 1'b1, 1'b0, wr, addr, data);
    @(posedge clk); #1;
    drive(w, 1'b1, 1'b1, wr, addr, data);
    done = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (rdyOf(w) == 8'd1) begin
        checkOutput("latency", w, 8'(k), 8'(waitOf[w] + 1));
        checkOutput("pslverr", w, errOf(w), {7'd0, expErr});
        checkOutput("prdata", w, rdOf(w), expRd);
        done = 1'b1;
      end else begin
        checkOutput("waitErr", w, errOf(w), 8'h00);
        checkOutput("waitRd", w, rdOf(w), 8'h00);
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      errors++;
      $error("[TB] FAIL timeout dut%0d observed=no_pready expected=pready", w);
    end
    if (done && wr && !expErr) mdl[w][addr[2:0]] = data;
    if (!b2b) drive(w, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("ctrlOut", w, ctrlOf(w), mdl[w][0]);
  endtask

  initial begin
    logic [7:0] a, d;
    logic       wr;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    modelReset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      checkOutput("rstReady", w, rdyOf(w), 8'h00);
      checkOutput("rstErr", w, errOf(w), 8'h00);
      checkOutput("rstRd", w, rdOf(w), 8'h00);
      checkOutput("rstCtrl", w, ctrlOf(w), 8'h00);
    end
    @(posedge clk); #1;

    $display("[TB] directed transfers, one wait state");
    applyStimulus(1, 1'b1, 8'd2, 8'h3C, 1'b0);
    applyStimulus(1, 1'b0, 8'd2, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 8'd0, 8'h81, 1'b0);
    applyStimulus(1, 1'b0, 8'd7, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 8'd7, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 8'd7, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 8'h20, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 8'h20, 8'hEE, 1'b0);
    applyStimulus(1, 1'b1, 8'd1, 8'h11, 1'b1);
    applyStimulus(1, 1'b1, 8'd2, 8'h22, 1'b1);
    applyStimulus(1, 1'b1, 8'd3, 8'h33, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1'b0, 8'(i), 8'h00, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    $display("[TB] directed transfers, zero wait states");
    applyStimulus(0, 1'b1, 8'd1, 8'hA1, 1'b1);
    applyStimulus(0, 1'b1, 8'd2, 8'hB2, 1'b1);
    applyStimulus(0, 1'b1, 8'd3, 8'hC3, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, 8'(i), 8'h00, 1'b1);
    applyStimulus(0, 1'b0, 8'hFF, 8'h00, 1'b0);

    $display("[TB] psel dropped mid-access");
    drive(1, 1'b1, 1'b0, 1'b1, 8'd1, 8'h77);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 8'd1, 8'h77);
    @(negedge clk);
    checkOutput("abortWait", 1, rdyOf(1), 8'h00);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 1'b1, 8'd1, 8'h77);
    @(negedge clk);
    checkOutput("abortReady", 1, rdyOf(1), 8'h00);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 8'd1, 8'h00, 1'b0);

    $display("[TB] reset during wait state");
    drive(1, 1'b1, 1'b0, 1'b1, 8'd1, 8'h55);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 8'd1, 8'h55);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstWait", 1, rdyOf(1), 8'h00);
    @(posedge clk); #1;
    modelReset();
    @(negedge clk);
    checkOutput("rstAbortRdy", 1, rdyOf(1), 8'h00);
    checkOutput("rstCtrl0", 0, ctrlOf(0), 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idleIgnoresEn", 1, rdyOf(1), 8'h00);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, 8'd1, 8'h00, 1'b0);
    applyStimulus(0, 1'b0, 8'd2, 8'h00, 1'b0);

    $display("[TB] random transfers");
    for (int n = 0; n < 120; n++) begin
      int w;
      w  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = 8'h20;
        1:       a = 8'(($urandom_range(8, 255)));
        default: a = 8'($urandom_range(0, 7));
      endcase
      d = 8'($urandom);
      applyStimulus(w, wr, a, d, 1'($urandom_range(0, 1)));
      drive(1 - w, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 8; i++) applyStimulus(w, 1'b0, 8'(i), 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
